mem_responder: RTL and testbench

- Memory-side target that answers the core's load/store/fetch requests.
- Word-organised SRAM with byte/halfword/word access, little-endian lanes and load sign/zero extension.
- Reports op, address-misalignment and access-range faults, matching the core's three memory fault inputs.
- Configurable wait states; request/response handshake.

---
 rtl/mem_responder.sv | 174 +++++++++++++++++
 tb/tb_mem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
//------------------------------------------------------------------------------
// Module  : mem_responder
// Brief   : Word-organised SRAM target answering load/store/fetch requests,
//           with lane select, load extension, fault flags and wait states.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_unsigned,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_op_fault,
  output logic        resp_addr_fault,
  output logic        resp_access_fault
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_L = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q;
  logic        op_fault_q, addr_fault_q, acc_fault_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [32:0]   w_offset;
  logic [AW-1:0] w_idx;
  logic          w_op, w_mis, w_range, w_addr_f, w_acc_f, w_any_f;
  logic          w_enter, w_mem_we;
  logic [31:0]   w_word, w_ld, w_wr;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    unsigned_d = unsigned_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          unsigned_d = req_unsigned;
          size_d     = req_size;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          if (WAIT_L == 4'd0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = WAIT_L;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode from the next-state request so a zero-wait access resolves on the accept edge.
  assign w_enter  = (state_d == ST_RESP);
  assign w_offset = {1'b0, addr_d} - {1'b0, BASE_ADDR};
  assign w_idx    = w_offset[AW+1:2];
  assign w_op     = (size_d == 2'b11);
  assign w_mis    = ((size_d == 2'b01) && addr_d[0]) ||
                    ((size_d == 2'b10) && (addr_d[1:0] != 2'b00));
  assign w_range  = w_offset[32] || (w_offset[31:AW+2] != '0);
  assign w_addr_f = !w_op && w_mis;
  assign w_acc_f  = !w_op && !w_mis && w_range;
  assign w_any_f  = w_op || w_mis || w_range;
  assign w_mem_we = w_enter && write_d && !w_any_f && !reset;
  assign w_word   = mem_q[w_idx];

  always_comb begin
    w_byte = w_word[{w_offset[1:0], 3'b000} +: 8];
    w_half = w_word[{w_offset[1], 4'b0000} +: 16];
    w_ld   = w_word;
    w_wr   = w_word;
    case (size_d)
      2'b00: begin
        w_ld = unsigned_d ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        w_wr[{w_offset[1:0], 3'b000} +: 8] = wdata_d[7:0];
      end
      2'b01: begin
        w_ld = unsigned_d ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        w_wr[{w_offset[1], 4'b0000} +: 16] = wdata_d[15:0];
      end
      2'b10:   w_wr = wdata_d;
      default: w_ld = w_word;
    endcase
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem_q[w_idx] <= w_wr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      op_fault_q   <= 1'b0;
      addr_fault_q <= 1'b0;
      acc_fault_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      unsigned_q <= unsigned_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if (w_enter) begin
        rdata_q      <= (write_d || w_any_f) ? 32'h0 : w_ld;
        op_fault_q   <= w_op;
        addr_fault_q <= w_addr_f;
        acc_fault_q  <= w_acc_f;
      end else begin
        rdata_q      <= 32'h0;
        op_fault_q   <= 1'b0;
        addr_fault_q <= 1'b0;
        acc_fault_q  <= 1'b0;
      end
    end
  end

  assign busy              = (state_q == ST_WAIT);
  assign resp_valid        = (state_q == ST_RESP);
  assign resp_rdata        = rdata_q;
  assign resp_op_fault     = op_fault_q;
  assign resp_addr_fault   = addr_fault_q;
  assign resp_access_fault = acc_fault_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_responder
// Brief   : Scoreboard bench for mem_responder, zero-wait and three-wait copies.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v0 = 1'b0, v3 = 1'b0;
  logic        r_wr = 1'b0, r_uns = 1'b0;
  logic [1:0]  r_sz = 2'b00;
  logic [31:0] r_addr = 32'h0, r_wd = 32'h0;

  logic        b0, rv0, op0, af0, xf0;
  logic        b3, rv3, op3, af3, xf3;
  logic [31:0] rd0, rd3;

  typedef struct packed {
    logic [31:0] rd;
    logic [2:0]  f;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   rc0 = 0;
  int   rc3 = 0;

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_d0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_write(r_wr),
    .req_unsigned(r_uns), .req_size(r_sz), .req_addr(r_addr), .req_wdata(r_wd),
    .busy(b0), .resp_valid(rv0), .resp_rdata(rd0), .resp_op_fault(op0),
    .resp_addr_fault(af0), .resp_access_fault(xf0));

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_d3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_write(r_wr),
    .req_unsigned(r_uns), .req_size(r_sz), .req_addr(r_addr), .req_wdata(r_wd),
    .busy(b3), .resp_valid(rv3), .resp_rdata(rd3), .resp_op_fault(op3),
    .resp_addr_fault(af3), .resp_access_fault(xf3));

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rv0) begin
      rc0++;
      chk_eq("pending0", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk_eq("rdata0", rd0, e.rd);
        chk_eq("fault0", {29'h0, op0, af0, xf0}, {29'h0, e.f});
      end
    end
    if (rv3) begin
      rc3++;
      chk_eq("pending3", 32'(q3.size() > 0), 32'd1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        chk_eq("rdata3", rd3, e.rd);
        chk_eq("fault3", {29'h0, op3, af3, xf3}, {29'h0, e.f});
      end
    end
  end

  task automatic set_req(input logic wr, input logic uns, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    r_wr = wr; r_uns = uns; r_sz = sz; r_addr = a; r_wd = wd;
  endtask

  // One transaction; hammer keeps req_valid high through busy and the response cycle.
  task automatic xact(input bit s3, input logic wr, input logic uns, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] erd, input logic [2:0] ef, input bit hammer);
    exp_t e;
    int   nw;
    @(negedge clk);
    set_req(wr, uns, sz, a, wd);
    e.rd = erd;
    e.f  = ef;
    if (s3) begin q3.push_back(e); v3 = 1'b1; end
    else    begin q0.push_back(e); v0 = 1'b1; end
    @(posedge clk);
    #1;
    if (!hammer) begin v0 = 1'b0; v3 = 1'b0; end
    nw = s3 ? 3 : 0;
    for (int k = 0; k < nw; k++) begin
      @(negedge clk);
      chk_eq("busy_wait", 32'(b3), 32'd1);
      chk_eq("early_valid", 32'(rv3), 32'd0);
    end
    @(negedge clk);
    chk_eq("latency", 32'(s3 ? rv3 : rv0), 32'd1);
    chk_eq("busy_in_resp", 32'(s3 ? b3 : b0), 32'd0);
    v0 = 1'b0;
    v3 = 1'b0;
    for (int k = 0; k < 20 && (q0.size() + q3.size()) != 0; k++) @(posedge clk);
    chk_eq("drain", 32'(q0.size() + q3.size()), 32'd0);
  endtask

  initial begin
    int base;
    repeat (2) @(negedge clk);
    chk_eq("rst_busy0", 32'(b0), 32'd0);
    chk_eq("rst_out0", {26'h0, rv0, op0, af0, xf0, b3, rv3}, 32'd0);
    chk_eq("rst_rdata", rd0 | rd3, 32'd0);
    reset = 1'b0;

    // Zero-wait instance: lanes, extension and faults.
    xact(0, 1, 0, 2'b10, 32'h10,   32'hDEADBEEF, 32'h0,        3'b000, 0);
    xact(0, 0, 0, 2'b10, 32'h10,   32'h0,        32'hDEADBEEF, 3'b000, 0);
    xact(0, 1, 0, 2'b00, 32'h13,   32'h00000080, 32'h0,        3'b000, 0);
    xact(0, 0, 0, 2'b00, 32'h13,   32'h0,        32'hFFFFFF80, 3'b000, 0);
    xact(0, 0, 1, 2'b00, 32'h13,   32'h0,        32'h00000080, 3'b000, 0);
    xact(0, 0, 0, 2'b10, 32'h10,   32'h0,        32'h80ADBEEF, 3'b000, 0);
    xact(0, 0, 0, 2'b01, 32'h11,   32'h0,        32'h0,        3'b010, 0);
    xact(0, 0, 0, 2'b11, 32'h11,   32'h0,        32'h0,        3'b100, 0);
    xact(0, 1, 0, 2'b01, 32'h12,   32'hFFFFA5A5, 32'h0,        3'b000, 0);
    xact(0, 0, 1, 2'b01, 32'h12,   32'h0,        32'h0000A5A5, 3'b000, 0);
    xact(0, 0, 0, 2'b01, 32'h12,   32'h0,        32'hFFFFA5A5, 3'b000, 0);
    xact(0, 0, 1, 2'b00, 32'h10,   32'h0,        32'h000000EF, 3'b000, 0);
    xact(0, 0, 0, 2'b10, 32'h10,   32'h0,        32'hA5A5BEEF, 3'b000, 0);
    xact(0, 1, 0, 2'b10, 32'h0,    32'h11223344, 32'h0,        3'b000, 0);
    xact(0, 1, 0, 2'b10, 32'h1000, 32'h99999999, 32'h0,        3'b001, 0);
    xact(0, 0, 0, 2'b10, 32'h1002, 32'h0,        32'h0,        3'b010, 0);
    xact(0, 0, 0, 2'b10, 32'h2,    32'h0,        32'h0,        3'b010, 0);
    xact(0, 0, 0, 2'b10, 32'h0,    32'h0,        32'h11223344, 3'b000, 0);

    // Three-wait instance: busy window and a request hammered while busy.
    base = rc3;
    xact(1, 1, 0, 2'b10, 32'h40,   32'hCAFEF00D, 32'h0,        3'b000, 1);
    repeat (8) @(posedge clk);
    #1;
    chk_eq("one_resp", 32'(rc3 - base), 32'd1);
    xact(1, 0, 0, 2'b10, 32'h40,   32'h0,        32'hCAFEF00D, 3'b000, 0);

    // Reset while a store waits: the store must be dropped.
    xact(1, 1, 0, 2'b10, 32'h20,   32'h55AA55AA, 32'h0,        3'b000, 0);
    @(negedge clk);
    set_req(1, 0, 2'b10, 32'h20, 32'h12345678);
    v3 = 1'b1;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    @(negedge clk);
    chk_eq("busy_pre_rst", 32'(b3), 32'd1);
    base = rc3;
    reset = 1'b1;
    #1;
    chk_eq("rst_mid_ctl", {27'h0, b3, rv3, op3, af3, xf3}, 32'd0);
    chk_eq("rst_mid_rdata", rd3, 32'd0);
    repeat (3) @(negedge clk);
    chk_eq("rst_hold", {27'h0, b3, rv3, op3, af3, xf3}, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk_eq("no_resp_after_rst", 32'(rc3 - base), 32'd0);
    xact(1, 0, 0, 2'b10, 32'h20,   32'h0,        32'h55AA55AA, 3'b000, 0);
    xact(0, 0, 0, 2'b10, 32'h10,   32'h0,        32'hA5A5BEEF, 3'b000, 0);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
